apb2axi_wr_data_tx: RTL and testbench

//  AXI3 write-data transmitter and write-response receiver of the APB2AXI converter.
//  - Pops wr_entry_t beats from the write data FIFO and drives the AXI W channel in AW-issue order.
//  - Takes B responses and turns them into completion_entry_t records for the completion queue.
//  - It is the write-direction counterpart of the R-channel read response handler.

---
 rtl/apb2axi_pkg.sv | 52 +++++
 rtl/apb2axi_ord_fifo.sv | 57 +++++
 rtl/apb2axi_wr_data_tx.sv | 183 ++++++++++++++++++
 tb/tb_apb2axi_wr_data_tx.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb2axi_pkg.sv
// Shared types and widths for the APB2AXI converter.
// Holds the write-data, completion and AW-order records.
package apb2axi_pkg;

    localparam int TAG_W       = 4;
    localparam int N_TAG       = 1 << TAG_W;
    localparam int AXI_ID_W    = 4;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_STRB_W  = AXI_DATA_W / 8;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_RESP_W  = 2;
    localparam int NUM_BEATS_W = AXI_LEN_W + 1;

    localparam logic [7:0] ERR_IDX_NONE = 8'hFF;

    typedef enum logic [AXI_RESP_W-1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic {
        WTX_IDLE,
        WTX_SEND
    } wtx_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [AXI_DATA_W-1:0] data;
        logic                  last;
        logic [AXI_STRB_W-1:0] wstrb;
    } wr_entry_t;

    typedef struct packed {
        logic                   is_write;
        logic [TAG_W-1:0]       tag;
        axi_resp_e              resp;
        logic                   error;
        logic [NUM_BEATS_W-1:0] num_beats;
        logic [7:0]             err_beat_idx;
    } completion_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [AXI_LEN_W-1:0] len;
    } aw_ord_t;

    localparam int DATA_ENTRY_W = $bits(wr_entry_t);
    localparam int CPL_W        = $bits(completion_entry_t);

endpackage

// File: rtl/apb2axi_ord_fifo.sv
// Generic synchronous FIFO with a combinational head view.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module apb2axi_ord_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/apb2axi_wr_data_tx.sv
// AXI3 W-channel transmitter and B-channel receiver for the APB2AXI converter.
// Sends write data in AW-issue order and turns B responses into completion records.
module apb2axi_wr_data_tx
    import apb2axi_pkg::*;
#(
    parameter int OST_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aw_iss_valid,
    input  logic [TAG_W-1:0]        aw_iss_tag,
    input  logic [AXI_LEN_W-1:0]    aw_iss_len,
    output logic                    aw_iss_ready,
    input  logic                    wdf_valid,
    input  logic [DATA_ENTRY_W-1:0] wdf_entry,
    output logic                    wdf_ready,
    output logic [AXI_ID_W-1:0]     wid,
    output logic [AXI_DATA_W-1:0]   wdata,
    output logic [AXI_STRB_W-1:0]   wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [AXI_ID_W-1:0]     bid,
    input  logic [AXI_RESP_W-1:0]   bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    cpl_valid,
    output logic [CPL_W-1:0]        cpl_entry,
    input  logic                    cpl_ready
);
    wtx_state_e             state;
    wtx_state_e             state_next;
    aw_ord_t                ord_head;
    aw_ord_t                ord_push_data;
    logic                   ord_full;
    logic                   ord_empty;
    logic                   ord_pop;
    logic                   push_ok;
    wr_entry_t              wdf_e;
    logic [TAG_W-1:0]       head_tag;
    logic [AXI_LEN_W-1:0]   head_len;
    logic [AXI_LEN_W-1:0]   beat_cnt;
    logic                   loaded_all;
    logic                   tag_err;
    logic                   is_last_beat;
    logic                   w_hs;
    logic                   load;
    logic                   b_hs;
    logic [TAG_W-1:0]       b_tag;
    completion_entry_t      cpl_q;
    logic [NUM_BEATS_W-1:0] num_beats_tbl [N_TAG];
    logic [7:0]             err_idx_tbl   [N_TAG];
    logic [N_TAG-1:0]       mism_tbl;

    assign wdf_e         = wr_entry_t'(wdf_entry);
    assign ord_push_data = '{tag: aw_iss_tag, len: aw_iss_len};
    assign push_ok       = aw_iss_valid && !rst && (!ord_full || ord_pop);
    assign aw_iss_ready  = !rst && !ord_full;

    apb2axi_ord_fifo #(
        .WIDTH ($bits(aw_ord_t)),
        .DEPTH (OST_DEPTH)
    ) u_ord_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (ord_push_data),
        .pop       (ord_pop),
        .head_data (ord_head),
        .full      (ord_full),
        .empty     (ord_empty)
    );

    // A tag mismatch desynchronises the data stream, so loading stays blocked until reset.
    assign is_last_beat = (beat_cnt == head_len);
    assign w_hs         = wvalid && wready;
    assign load         = (!wvalid || wready) && (state == WTX_SEND) && !loaded_all
                          && !tag_err && wdf_valid && (wdf_e.tag == head_tag);
    assign wdf_ready    = load;

    always_comb begin
        state_next = state;
        ord_pop    = 1'b0;
        case (state)
            WTX_IDLE: if (!ord_empty) state_next = WTX_SEND;
            WTX_SEND: begin
                if (w_hs && wlast) begin
                    state_next = WTX_IDLE;
                    ord_pop    = 1'b1;
                end
            end
            default: state_next = WTX_IDLE;
        endcase
    end

    // loaded_all stops a same-tag follow-on burst being pulled in before wlast drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WTX_IDLE;
            head_tag   <= '0;
            head_len   <= '0;
            beat_cnt   <= '0;
            loaded_all <= 1'b0;
            tag_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == WTX_IDLE && !ord_empty) begin
                head_tag   <= ord_head.tag;
                head_len   <= ord_head.len;
                beat_cnt   <= '0;
                loaded_all <= 1'b0;
            end else if (load) begin
                beat_cnt <= beat_cnt + AXI_LEN_W'(1);
                if (is_last_beat) loaded_all <= 1'b1;
            end
            if (state == WTX_SEND && !loaded_all && wdf_valid && wdf_e.tag != head_tag) begin
                tag_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
            wid    <= '0;
            wdata  <= '0;
            wstrb  <= '0;
        end else if (load) begin
            wvalid <= 1'b1;
            wlast  <= is_last_beat;
            wid    <= AXI_ID_W'(head_tag);
            wdata  <= wdf_e.data;
            wstrb  <= wdf_e.wstrb;
        end else if (w_hs) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
        end
    end

    // A push for a tag is applied after the mismatch update so a new write always starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            mism_tbl <= '0;
            for (int i = 0; i < N_TAG; i++) begin
                num_beats_tbl[i] <= '0;
                err_idx_tbl[i]   <= '0;
            end
        end else begin
            if (load && (wdf_e.last != is_last_beat) && !mism_tbl[head_tag]) begin
                mism_tbl[head_tag]    <= 1'b1;
                err_idx_tbl[head_tag] <= beat_cnt;
            end
            if (push_ok) begin
                num_beats_tbl[aw_iss_tag] <= NUM_BEATS_W'(aw_iss_len) + NUM_BEATS_W'(1);
                mism_tbl[aw_iss_tag]      <= 1'b0;
            end
        end
    end

    assign bready    = !rst && (!cpl_valid || cpl_ready);
    assign b_hs      = bvalid && bready;
    assign b_tag     = bid[TAG_W-1:0];
    assign cpl_entry = cpl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpl_valid <= 1'b0;
            cpl_q     <= '0;
        end else if (b_hs) begin
            cpl_valid          <= 1'b1;
            cpl_q.is_write     <= 1'b1;
            cpl_q.tag          <= b_tag;
            cpl_q.resp         <= axi_resp_e'(bresp);
            cpl_q.error        <= bresp[1] | mism_tbl[b_tag];
            cpl_q.num_beats    <= num_beats_tbl[b_tag];
            cpl_q.err_beat_idx <= mism_tbl[b_tag] ? err_idx_tbl[b_tag] : ERR_IDX_NONE;
        end else if (cpl_ready) begin
            cpl_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb2axi_wr_data_tx.sv
// Directed bench for apb2axi_wr_data_tx: W ordering, stalls, completions, back-pressure and reset.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_apb2axi_wr_data_tx;
    import apb2axi_pkg::*;

    localparam int OST_DEPTH = 4;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } wbeat_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  aw_iss_valid;
    logic [TAG_W-1:0]      aw_iss_tag;
    logic [AXI_LEN_W-1:0]  aw_iss_len;
    logic                  aw_iss_ready;
    logic                  wdf_valid;
    wr_entry_t             wdf_entry;
    logic                  wdf_ready;
    logic [AXI_ID_W-1:0]   wid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [AXI_RESP_W-1:0] bresp;
    logic                  bvalid;
    logic                  bready;
    logic                  cpl_valid;
    completion_entry_t     cpl_entry;
    logic                  cpl_ready;

    wr_entry_t         wdf_q[$];
    wbeat_t            exp_w[$];
    wbeat_t            hs_beats[$];
    int                hs_cyc[$];
    int                pop_cyc[$];
    completion_entry_t cpl_log[$];
    int                cpl_cyc[$];
    int                bhs_cyc;
    int                cyc;
    int                checks;
    int                errors;
    bit                wr_toggle;
    bit                aw_pend;
    logic [TAG_W-1:0]  aw_pend_tag;
    logic [7:0]        aw_pend_len;
    bit                b_pend;
    logic [3:0]        b_pend_id;
    logic [1:0]        b_pend_resp;

    apb2axi_wr_data_tx #(.OST_DEPTH(OST_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .aw_iss_valid (aw_iss_valid),
        .aw_iss_tag   (aw_iss_tag),
        .aw_iss_len   (aw_iss_len),
        .aw_iss_ready (aw_iss_ready),
        .wdf_valid    (wdf_valid),
        .wdf_entry    (wdf_entry),
        .wdf_ready    (wdf_ready),
        .wid          (wid),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .wvalid       (wvalid),
        .wready       (wready),
        .bid          (bid),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .cpl_valid    (cpl_valid),
        .cpl_entry    (cpl_entry),
        .cpl_ready    (cpl_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic wr_entry_t mkEntry(input int tag, input int data, input bit last);
        wr_entry_t e;
        e.tag   = TAG_W'(tag);
        e.data  = AXI_DATA_W'(data);
        e.last  = last;
        e.wstrb = 4'hF;
        return e;
    endfunction

    function automatic wbeat_t mkBeat(input int tag, input int data, input bit last);
        wbeat_t b;
        b.id   = AXI_ID_W'(tag);
        b.data = AXI_DATA_W'(data);
        b.strb = 4'hF;
        b.last = last;
        return b;
    endfunction

    function automatic completion_entry_t mkCpl(input int tag, input int resp, input bit err,
                                                input int nb, input int idx);
        completion_entry_t c;
        c.is_write     = 1'b1;
        c.tag          = TAG_W'(tag);
        c.resp         = axi_resp_e'(resp[1:0]);
        c.error        = err;
        c.num_beats    = NUM_BEATS_W'(nb);
        c.err_beat_idx = 8'(idx);
        return c;
    endfunction

    // One clock cycle: drive inputs at the falling edge, then observe and update the models.
    task automatic applyStimulus();
        wbeat_t    cur;
        wr_entry_t dump;
        @(negedge clk);
        cyc++;
        aw_iss_valid = aw_pend;
        aw_iss_tag   = aw_pend_tag;
        aw_iss_len   = aw_pend_len;
        aw_pend      = 1'b0;
        wdf_valid    = (wdf_q.size() > 0);
        wdf_entry    = wdf_valid ? wdf_q[0] : '0;
        wready       = wr_toggle ? cyc[0] : 1'b1;
        bvalid       = b_pend;
        bid          = b_pend_id;
        bresp        = b_pend_resp;
        #1;
        if (!rst) begin
            cur = {wid, wdata, wstrb, wlast};
            if (wvalid) begin
                if (exp_w.size() == 0) checkOutput("w_unexpected_valid", 64'(wvalid), 64'd0);
                else                   checkOutput("w_beat", 64'(cur), 64'(exp_w[0]));
                if (wready) begin
                    hs_beats.push_back(cur);
                    hs_cyc.push_back(cyc);
                    if (exp_w.size() > 0) cur = exp_w.pop_front();
                end
            end
            if (wdf_ready) begin
                dump = wdf_q.pop_front();
                pop_cyc.push_back(cyc);
            end
            if (bvalid && bready) begin
                b_pend  = 1'b0;
                bhs_cyc = cyc;
            end
            if (cpl_valid && cpl_ready) begin
                cpl_log.push_back(cpl_entry);
                cpl_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic drainW(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_w.size() > 0 || aw_pend) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_beats_left"}, 64'(exp_w.size()), 64'd0);
        repeat (3) applyStimulus();
    endtask

    task automatic sendB(input string tag, input int id, input int resp, input completion_entry_t exp_c);
        int n;
        int base;
        base        = cpl_log.size();
        b_pend      = 1'b1;
        b_pend_id   = 4'(id);
        b_pend_resp = 2'(resp);
        n = 0;
        while (cpl_log.size() == base && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_cpl_count"}, 64'(cpl_log.size() - base), 64'd1);
        if (cpl_log.size() > base) begin
            checkOutput({tag, "_cpl_entry"}, 64'(cpl_log[base]), 64'(exp_c));
            checkOutput({tag, "_cpl_latency"}, 64'(cpl_cyc[base] - bhs_cyc), 64'd1);
        end
    endtask

    initial begin
        int  h0;
        int  p0;
        bit  rdy [5];

        checks = 0; errors = 0; cyc = 0;
        wr_toggle = 0; aw_pend = 0; b_pend = 0;
        aw_pend_tag = '0; aw_pend_len = '0; b_pend_id = '0; b_pend_resp = '0;
        cpl_ready = 1'b1;
        rst = 1'b1;
        repeat (3) applyStimulus();
        checkOutput("rst_ctrl", 64'({wvalid, wlast, wdf_ready, bready, cpl_valid, aw_iss_ready}), 64'd0);
        checkOutput("rst_wdata", 64'({wid, wdata, wstrb}), 64'd0);
        checkOutput("rst_cpl_entry", 64'(cpl_entry), 64'd0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("idle_ready", 64'({aw_iss_ready, bready, wvalid}), 64'b110);

        $display("[TB] single burst, tag 3 len 3, wready high");
        for (int i = 0; i < 4; i++) begin
            wdf_q.push_back(mkEntry(3, 32'hA000_0000 + i, i == 3));
            exp_w.push_back(mkBeat(3, 32'hA000_0000 + i, i == 3));
        end
        h0 = hs_cyc.size(); p0 = pop_cyc.size();
        aw_pend = 1; aw_pend_tag = 4'd3; aw_pend_len = 8'd3;
        drainW("t1", 40);
        checkOutput("t1_hs_count", 64'(hs_cyc.size() - h0), 64'd4);
        if (hs_cyc.size() - h0 == 4 && pop_cyc.size() > p0) begin
            for (int i = 1; i < 4; i++) checkOutput("t1_consecutive", 64'(hs_cyc[h0+i] - hs_cyc[h0+i-1]), 64'd1);
            checkOutput("t1_pop_to_valid", 64'(hs_cyc[h0] - pop_cyc[p0]), 64'd1);
        end
        sendB("t1", 3, 0, mkCpl(3, 0, 0, 4, 8'hFF));

        $display("[TB] single burst with wready toggling");
        wr_toggle = 1;
        for (int i = 0; i < 4; i++) begin
            wdf_q.push_back(mkEntry(3, 32'hB000_0000 + i, i == 3));
            exp_w.push_back(mkBeat(3, 32'hB000_0000 + i, i == 3));
        end
        h0 = hs_cyc.size(); p0 = pop_cyc.size();
        aw_pend = 1; aw_pend_tag = 4'd3; aw_pend_len = 8'd3;
        drainW("t2", 60);
        wr_toggle = 0;
        checkOutput("t2_hs_count", 64'(hs_cyc.size() - h0), 64'd4);
        checkOutput("t2_pop_count", 64'(pop_cyc.size() - p0), 64'd4);

        $display("[TB] two bursts, tag 1 len 0 then tag 2 len 1");
        wdf_q.push_back(mkEntry(1, 32'hC100_0000, 1'b1));
        wdf_q.push_back(mkEntry(2, 32'hC200_0000, 1'b0));
        wdf_q.push_back(mkEntry(2, 32'hC200_0001, 1'b1));
        exp_w.push_back(mkBeat(1, 32'hC100_0000, 1'b1));
        exp_w.push_back(mkBeat(2, 32'hC200_0000, 1'b0));
        exp_w.push_back(mkBeat(2, 32'hC200_0001, 1'b1));
        h0 = hs_cyc.size();
        aw_pend = 1; aw_pend_tag = 4'd1; aw_pend_len = 8'd0;
        applyStimulus();
        aw_pend = 1; aw_pend_tag = 4'd2; aw_pend_len = 8'd1;
        drainW("t3", 40);
        checkOutput("t3_hs_count", 64'(hs_cyc.size() - h0), 64'd3);
        if (hs_cyc.size() - h0 == 3) begin
            checkOutput("t3_bubble", 64'(hs_cyc[h0+1] - hs_cyc[h0] > 1), 64'd1);
            checkOutput("t3_b2b", 64'(hs_cyc[h0+2] - hs_cyc[h0+1]), 64'd1);
        end
        sendB("t3a", 2, 0, mkCpl(2, 0, 0, 2, 8'hFF));
        sendB("t3b", 1, 2, mkCpl(1, 2, 1, 1, 8'hFF));

        $display("[TB] early last flag on beat 0 of a len 1 burst");
        wdf_q.push_back(mkEntry(5, 32'hD500_0000, 1'b1));
        wdf_q.push_back(mkEntry(5, 32'hD500_0001, 1'b1));
        exp_w.push_back(mkBeat(5, 32'hD500_0000, 1'b0));
        exp_w.push_back(mkBeat(5, 32'hD500_0001, 1'b1));
        aw_pend = 1; aw_pend_tag = 4'd5; aw_pend_len = 8'd1;
        drainW("t4", 40);
        sendB("t4", 5, 0, mkCpl(5, 0, 1, 2, 0));

        $display("[TB] reset in the middle of a burst");
        for (int i = 0; i < 4; i++) begin
            wdf_q.push_back(mkEntry(7, 32'hE700_0000 + i, i == 3));
            exp_w.push_back(mkBeat(7, 32'hE700_0000 + i, i == 3));
        end
        h0 = hs_cyc.size();
        aw_pend = 1; aw_pend_tag = 4'd7; aw_pend_len = 8'd3;
        for (int n = 0; n < 30 && hs_cyc.size() - h0 < 2; n++) applyStimulus();
        checkOutput("t6_partial", 64'(hs_cyc.size() - h0), 64'd2);
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("t6_rst_ctrl", 64'({wvalid, wlast, wdf_ready, bready, cpl_valid}), 64'd0);
        checkOutput("t6_rst_wdata", 64'({wid, wdata}), 64'd0);
        wdf_q.delete();
        exp_w.delete();
        rst = 1'b0;
        applyStimulus();
        wdf_q.push_back(mkEntry(7, 32'hF700_0000, 1'b0));
        wdf_q.push_back(mkEntry(7, 32'hF700_0001, 1'b1));
        exp_w.push_back(mkBeat(7, 32'hF700_0000, 1'b0));
        exp_w.push_back(mkBeat(7, 32'hF700_0001, 1'b1));
        h0 = hs_cyc.size();
        aw_pend = 1; aw_pend_tag = 4'd7; aw_pend_len = 8'd1;
        drainW("t6", 40);
        checkOutput("t6_hs_count", 64'(hs_cyc.size() - h0), 64'd2);
        sendB("t6", 7, 0, mkCpl(7, 0, 0, 2, 8'hFF));

        $display("[TB] order queue back-pressure and head tag mismatch");
        for (int i = 0; i < 5; i++) begin
            aw_pend = 1; aw_pend_tag = 4'(8 + i); aw_pend_len = 8'd0;
            applyStimulus();
            rdy[i] = aw_iss_ready;
        end
        applyStimulus();
        checkOutput("t5_ready_at_3", 64'(rdy[3]), 64'd1);
        checkOutput("t5_ready_at_4", 64'(rdy[4]), 64'd0);
        checkOutput("t5_ready_after", 64'(aw_iss_ready), 64'd0);
        wdf_q.push_back(mkEntry(12, 32'h1200_0000, 1'b1));
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("t5_wdf_ready", 64'(wdf_ready), 64'd0);
            checkOutput("t5_wvalid", 64'(wvalid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
